// File: rtl/datapath_pkg.sv
// Shared op codes, sequencer states and bus-source encodings for seq_datapath.
// No logic here; latency and backpressure belong to the modules that use it.
package datapath_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_SHL = 4'd4;
  localparam logic [3:0] OP_SHR = 4'd5;
  localparam logic [3:0] OP_MUL = 4'd6;
  localparam logic [3:0] OP_NEG = 4'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_T1,
    ST_T2,
    ST_T3,
    ST_T4
  } state_t;

  typedef enum logic [1:0] {
    BUS_RB,
    BUS_RC,
    BUS_ZLO,
    BUS_ZHI
  } bus_src_e;

  localparam int NBUS_SRC = 4;

  function automatic bus_src_e oh_to_idx(input logic [NBUS_SRC-1:0] oh);
    bus_src_e idx;
    idx = BUS_RB;
    for (int i = 0; i < NBUS_SRC; i++) begin
      if (oh[i]) idx = bus_src_e'(2'(i));
    end
    return idx;
  endfunction

endpackage

// File: rtl/alu_unit.sv
// Combinational ALU producing a double-width result; zero latency, no handshake.
// Codes with op[3] set are flagged illegal and yield zero.
module alu_unit
  import datapath_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]   i_y,
  input  logic [WIDTH-1:0]   i_b,
  input  logic [3:0]         i_op,
  output logic [2*WIDTH-1:0] o_res,
  output logic               o_illegal
);

  localparam int SW = $clog2(WIDTH);

  logic [SW-1:0]    w_sh;
  logic [WIDTH-1:0] w_lo;

  assign w_sh = i_b[SW-1:0];

  always_comb begin
    w_lo      = '0;
    o_illegal = 1'b0;
    o_res     = '0;
    case (i_op)
      OP_ADD: w_lo = i_y + i_b;
      OP_SUB: w_lo = i_y - i_b;
      OP_AND: w_lo = i_y & i_b;
      OP_OR:  w_lo = i_y | i_b;
      OP_SHL: w_lo = i_y << w_sh;
      OP_SHR: w_lo = i_y >> w_sh;
      OP_NEG: w_lo = '0 - i_y;
      OP_MUL: ;
      default: o_illegal = 1'b1;
    endcase
    // Only MUL populates the upper half; everything else leaves Zhi at zero.
    if (i_op == OP_MUL) o_res = (2*WIDTH)'(i_y) * (2*WIDTH)'(i_b);
    else                o_res = {{WIDTH{1'b0}}, w_lo};
  end

endmodule

// File: rtl/seq_datapath.sv
// Single-bus datapath running one reg-reg op per start; done 4 cycles after accept (5 for MUL).
// start is accepted only while idle; start/load while busy are dropped, never queued.
module seq_datapath
  import datapath_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int NREGS   = 16,
  parameter bit R0_ZERO = 1'b1
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     start,
  input  logic [3:0]               op,
  input  logic [$clog2(NREGS)-1:0] ra,
  input  logic [$clog2(NREGS)-1:0] rb,
  input  logic [$clog2(NREGS)-1:0] rc,
  input  logic                     load_en,
  input  logic [$clog2(NREGS)-1:0] load_idx,
  input  logic [WIDTH-1:0]         load_data,
  input  logic [$clog2(NREGS)-1:0] rd_idx,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [WIDTH-1:0]         hi,
  output logic [WIDTH-1:0]         lo
);

  localparam int RW = $clog2(NREGS);

  logic [WIDTH-1:0]   r_regs [NREGS];
  state_t             r_state;
  state_t             w_next;
  logic [3:0]         r_op;
  logic [RW-1:0]      r_ra;
  logic [RW-1:0]      r_rb;
  logic [RW-1:0]      r_rc;
  logic [WIDTH-1:0]   r_y;
  logic [2*WIDTH-1:0] r_z;
  logic               r_ill;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_done;
  logic               r_err;

  logic [NBUS_SRC-1:0] w_sel_oh;
  bus_src_e            w_sel_idx;
  logic [WIDTH-1:0]    w_bus;
  logic                w_y_en;
  logic                w_z_en;
  logic                w_lo_en;
  logic                w_hi_en;
  logic                w_rf_we;
  logic                w_fin;
  logic                w_accept;
  logic                w_load;
  logic [2*WIDTH-1:0]  w_alu_res;
  logic                w_alu_ill;

  function automatic logic [WIDTH-1:0] read_reg(input logic [RW-1:0] idx);
    if (R0_ZERO && idx == '0) return '0;
    return r_regs[idx];
  endfunction

  assign w_accept = start && (r_state == ST_IDLE);
  assign w_load   = load_en && (r_state == ST_IDLE);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_next = ST_T1;
      ST_T1:   w_next = ST_T2;
      ST_T2:   w_next = ST_T3;
      ST_T3:   w_next = (!r_ill && r_op == OP_MUL) ? ST_T4 : ST_IDLE;
      ST_T4:   w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_sel_oh = '0;
    w_y_en   = 1'b0;
    w_z_en   = 1'b0;
    w_lo_en  = 1'b0;
    w_hi_en  = 1'b0;
    w_rf_we  = 1'b0;
    w_fin    = 1'b0;
    case (r_state)
      ST_T1: begin
        w_sel_oh[BUS_RB] = 1'b1;
        w_y_en           = 1'b1;
      end
      ST_T2: begin
        w_sel_oh[BUS_RC] = 1'b1;
        w_z_en           = 1'b1;
      end
      ST_T3: begin
        w_sel_oh[BUS_ZLO] = 1'b1;
        if (r_ill) begin
          w_fin = 1'b1;
        end else if (r_op == OP_MUL) begin
          w_lo_en = 1'b1;
        end else begin
          w_rf_we = 1'b1;
          w_fin   = 1'b1;
        end
      end
      ST_T4: begin
        w_sel_oh[BUS_ZHI] = 1'b1;
        w_hi_en           = 1'b1;
        w_fin             = 1'b1;
      end
      default: ;
    endcase
  end

  // One-hot select is reduced to an index; an empty select (IDLE) parks the bus at zero.
  assign w_sel_idx = oh_to_idx(w_sel_oh);

  always_comb begin
    w_bus = '0;
    if (|w_sel_oh) begin
      case (w_sel_idx)
        BUS_RB:  w_bus = read_reg(r_rb);
        BUS_RC:  w_bus = read_reg(r_rc);
        BUS_ZLO: w_bus = r_z[WIDTH-1:0];
        BUS_ZHI: w_bus = r_z[2*WIDTH-1:WIDTH];
        default: w_bus = '0;
      endcase
    end
  end

  alu_unit #(.WIDTH(WIDTH)) u_alu (
    .i_y       (r_y),
    .i_b       (w_bus),
    .i_op      (r_op),
    .o_res     (w_alu_res),
    .o_illegal (w_alu_ill)
  );

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_op <= '0;
      r_ra <= '0;
      r_rb <= '0;
      r_rc <= '0;
    end else if (w_accept) begin
      r_op <= op;
      r_ra <= ra;
      r_rb <= rb;
      r_rc <= rc;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_y   <= '0;
      r_z   <= '0;
      r_ill <= 1'b0;
      r_hi  <= '0;
      r_lo  <= '0;
    end else begin
      if (w_y_en) r_y <= w_bus;
      if (w_z_en) begin
        r_z   <= w_alu_res;
        r_ill <= w_alu_ill;
      end
      if (w_lo_en) r_lo <= w_bus;
      if (w_hi_en) r_hi <= w_bus;
    end
  end

  // Preload and T3 writeback never coincide: one needs IDLE, the other T3.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (w_load) begin
      if (!(R0_ZERO && load_idx == '0)) r_regs[load_idx] <= load_data;
    end else if (w_rf_we) begin
      if (!(R0_ZERO && r_ra == '0)) r_regs[r_ra] <= w_bus;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_done <= w_fin;
      r_err  <= w_fin && r_ill;
    end
  end

  assign rd_data = read_reg(rd_idx);
  assign busy    = (r_state != ST_IDLE);
  assign done    = r_done;
  assign err     = r_err;
  assign hi      = r_hi;
  assign lo      = r_lo;

endmodule

// File: tb/tb_seq_datapath.sv
// Scoreboard bench for seq_datapath: stimulus pushes expected completions, a monitor checks each done pulse.
module tb_seq_datapath;

  logic        clk = 1'b0;
  logic        clr;
  logic        start;
  logic [3:0]  op;
  logic [3:0]  ra, rb, rc;
  logic        load_en;
  logic [3:0]  load_idx;
  logic [31:0] load_data;
  logic [3:0]  rd_idx;
  logic [31:0] rd_data;
  logic        busy, done, err;
  logic [31:0] hi, lo;

  seq_datapath #(.WIDTH(32), .NREGS(16), .R0_ZERO(1'b1)) dut (
    .clk       (clk),
    .clr       (clr),
    .start     (start),
    .op        (op),
    .ra        (ra),
    .rb        (rb),
    .rc        (rc),
    .load_en   (load_en),
    .load_idx  (load_idx),
    .load_data (load_data),
    .rd_idx    (rd_idx),
    .rd_data   (rd_data),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        err;
    logic        chk_rd;
    logic [31:0] rd_exp;
    logic [31:0] hi_exp;
    logic [31:0] lo_exp;
    int          due;
  } exp_t;

  exp_t        sb_q[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  logic [31:0] exp_hi = 0;
  logic [31:0] exp_lo = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got=0x%08h want=0x%08h (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (clr === 1'b1 && done === 1'b1) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got=1 want=0 (t=%0t)", $time);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("err", {31'd0, err}, {31'd0, e.err});
        chk("latency_cycle", cyc, e.due);
        chk("hi", hi, e.hi_exp);
        chk("lo", lo, e.lo_exp);
        if (e.chk_rd) chk("rd_data", rd_data, e.rd_exp);
      end
    end
  end

  task automatic preload(input logic [3:0] idx, input logic [31:0] val);
    load_en   = 1'b1;
    load_idx  = idx;
    load_data = val;
    @(posedge clk); #1;
    load_en = 1'b0;
  endtask

  // Drives one start for a cycle; called just after a rising edge.
  task automatic issue(input logic [3:0] op_i, input logic [3:0] ra_i, input logic [3:0] rb_i,
                       input logic [3:0] rc_i, input bit push, input bit e_err, input bit chk_rd,
                       input logic [3:0] rdi, input logic [31:0] rdv, input int lat,
                       input bit ld, input logic [3:0] li, input logic [31:0] lv);
    exp_t e;
    start     = 1'b1;
    op        = op_i;
    ra        = ra_i;
    rb        = rb_i;
    rc        = rc_i;
    rd_idx    = rdi;
    load_en   = ld;
    load_idx  = li;
    load_data = lv;
    if (push) begin
      e.err    = e_err;
      e.chk_rd = chk_rd;
      e.rd_exp = rdv;
      e.hi_exp = exp_hi;
      e.lo_exp = exp_lo;
      e.due    = cyc + lat;
      sb_q.push_back(e);
    end
    @(posedge clk); #1;
    start   = 1'b0;
    load_en = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && sb_q.size() != 0; i++) @(posedge clk);
    #1;
    chk("drain_pending", sb_q.size(), 0);
  endtask

  task automatic readback(input string name, input logic [3:0] idx, input logic [31:0] val);
    rd_idx = idx;
    #1;
    chk(name, rd_data, val);
  endtask

  initial begin
    clr = 1'b0; start = 1'b0; op = '0; ra = '0; rb = '0; rc = '0;
    load_en = 1'b0; load_idx = '0; load_data = '0; rd_idx = 4'd5;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_err", {31'd0, err}, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_rd", rd_data, 0);
    clr = 1'b1;
    @(posedge clk); #1;

    // ADD: 0x34 + 0x45 = 0x79
    preload(4'd2, 32'h0000_0034);
    preload(4'd3, 32'h0000_0045);
    issue(4'd0, 4'd1, 4'd2, 4'd3, 1, 0, 1, 4'd1, 32'h79, 4, 0, 0, 0);
    chk("busy_after_accept", {31'd0, busy}, 1);
    drain();

    // MUL: 0xFFFFFFFF * 2 = 0x1_FFFFFFFE; R1 untouched
    preload(4'd4, 32'hFFFF_FFFF);
    preload(4'd5, 32'h0000_0002);
    exp_hi = 32'h0000_0001;
    exp_lo = 32'hFFFF_FFFE;
    issue(4'd6, 4'd1, 4'd4, 4'd5, 1, 0, 1, 4'd1, 32'h79, 5, 0, 0, 0);
    drain();

    // Shift amount uses only the low 5 bits of 33, i.e. 1
    preload(4'd6, 32'h8000_0001);
    preload(4'd7, 32'd33);
    issue(4'd4, 4'd8, 4'd6, 4'd7, 1, 0, 1, 4'd8, 32'h0000_0002, 4, 0, 0, 0);
    drain();
    issue(4'd5, 4'd8, 4'd6, 4'd7, 1, 0, 1, 4'd8, 32'h4000_0000, 4, 0, 0, 0);
    drain();

    // Illegal op: err, no write
    issue(4'hA, 4'd9, 4'd2, 4'd3, 1, 1, 1, 4'd9, 32'h0, 4, 0, 0, 0);
    drain();
    // Write to R0 is discarded but completes normally
    issue(4'd0, 4'd0, 4'd2, 4'd3, 1, 0, 1, 4'd0, 32'h0, 4, 0, 0, 0);
    drain();

    // SUB with ignored start/load while busy, then back-to-back NEG in the done cycle
    issue(4'd1, 4'd10, 4'd3, 4'd2, 1, 0, 1, 4'd10, 32'h11, 4, 0, 0, 0);
    start = 1'b1; op = 4'd0; ra = 4'd11; rb = 4'd2; rc = 4'd3;
    load_en = 1'b1; load_idx = 4'd3; load_data = 32'h0000_DEAD;
    @(posedge clk); #1;
    start = 1'b0; load_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("done_cycle_busy", {31'd0, busy}, 0);
    issue(4'd7, 4'd12, 4'd2, 4'd3, 1, 0, 0, 4'd10, 32'h0, 4, 0, 0, 0);
    drain();
    readback("neg_result", 4'd12, 32'hFFFF_FFCC);
    readback("ignored_start", 4'd11, 32'h0);
    readback("ignored_load", 4'd3, 32'h0000_0045);

    // Same-edge load+start, ra==rb==rc: 5 + 5 = 0xA using the freshly loaded value
    issue(4'd0, 4'd13, 4'd13, 4'd13, 1, 0, 1, 4'd13, 32'h0000_000A, 4, 1, 4'd13, 32'h5);
    drain();

    // Reset during T2 aborts the ADD
    issue(4'd0, 4'd15, 4'd2, 4'd3, 0, 0, 0, 4'd15, 32'h0, 4, 0, 0, 0);
    @(posedge clk); #1;
    clr = 1'b0;
    exp_hi = 0;
    exp_lo = 0;
    #1;
    chk("abort_busy", {31'd0, busy}, 0);
    chk("abort_done", {31'd0, done}, 0);
    chk("abort_err", {31'd0, err}, 0);
    chk("abort_hi", hi, 0);
    chk("abort_lo", lo, 0);
    readback("abort_dest", 4'd15, 32'h0);
    readback("abort_src_cleared", 4'd2, 32'h0);
    @(posedge clk); #1;
    clr = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("post_abort_busy", {31'd0, busy}, 0);
    readback("post_abort_dest", 4'd15, 32'h0);
    chk("sb_empty", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
